// File: rtl/dut_sobel_system_pkg.sv
// Shared constants and helpers for the Sobel edge-detect pipeline.
// Latency/backpressure: none (package only).
package dut_sobel_system_pkg;
   localparam int BYTE       = 8;
   localparam int PIXEL_BITS = 24;
   localparam int GRAD_BITS  = 11;

   // Ceil-log2 with a floor of 1 so single-entry structures still get a bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // One gray byte of a 3-row column, widened to the signed gradient width.
   function automatic logic signed [GRAD_BITS-1:0] px(input logic [3*BYTE-1:0] col, input int row);
      return $signed(GRAD_BITS'(col[row*BYTE +: BYTE]));
   endfunction
endpackage

// File: rtl/dut_sobel_system_sync_fifo.sv
// First-word-fall-through FIFO: dout shows head while !empty, zero when empty.
// Writes while full are dropped, reads while empty ignored; async active-high reset.
module sync_fifo
   import dut_sobel_system_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_wr_en,
   input  logic [DWIDTH-1:0]         i_din,
   output logic                      o_full,
   input  logic                      i_rd_en,
   output logic [DWIDTH-1:0]         o_dout,
   output logic                      o_empty,
   output logic [clog2(DEPTH+1)-1:0] o_count
);
   localparam int PW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_wr;
   logic              w_rd;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_wr    = i_wr_en && !o_full;
   assign w_rd    = i_rd_en && !o_empty;
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
         if (w_rd) r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_din;
   end
endmodule

// File: rtl/dut_sobel_system.sv
// RGB column FIFO -> 3 grayscale converters -> 3x3 Sobel -> byte FIFO; 4 edges write-to-output.
// Each stage pops only when the downstream FIFO has room for its in-flight register, so stalls propagate losslessly.
module dut_sobel_system
   import dut_sobel_system_pkg::*;
#(
   parameter int NUM_SOBELS       = 1,
   parameter int NUM_GRAYSCALES   = 3 * NUM_SOBELS,
   parameter int RGB_DWIDTH       = PIXEL_BITS * NUM_GRAYSCALES,
   parameter int RGB_BUFFER       = 2,
   parameter int GRAYSCALE_DWIDTH = BYTE * NUM_GRAYSCALES,
   parameter int GRAYSCALE_BUFFER = 2,
   parameter int SOBEL_DWIDTH     = BYTE * NUM_SOBELS,
   parameter int SOBEL_BUFFER     = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
   output logic                    fifo_rgb_full,
   input  logic                    fifo_rgb_wr_en,
   output logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
   output logic                    fifo_sobel_empty,
   input  logic                    fifo_sobel_rd_en
);
   localparam int RCW = clog2(RGB_BUFFER + 1);
   localparam int GCW = clog2(GRAYSCALE_BUFFER + 1);
   localparam int SCW = clog2(SOBEL_BUFFER + 1);

   logic [RGB_DWIDTH-1:0]       w_rgb_dout;
   logic                        w_rgb_empty;
   logic                        w_rgb_pop;
   logic [RCW-1:0]              w_rgb_count_unused;
   logic [GRAYSCALE_DWIDTH-1:0] w_gray;
   logic [GRAYSCALE_DWIDTH-1:0] r_gray_dat;
   logic                        r_gray_vld;
   logic [GRAYSCALE_DWIDTH-1:0] w_gray_dout;
   logic                        w_gray_full;
   logic                        w_gray_empty;
   logic                        w_gray_pop;
   logic [GCW-1:0]              w_gray_count;
   logic [GCW:0]                w_gray_occ;
   logic [GRAYSCALE_DWIDTH-1:0] r_win1;
   logic [GRAYSCALE_DWIDTH-1:0] r_win2;
   logic signed [GRAD_BITS-1:0] w_gx;
   logic signed [GRAD_BITS-1:0] w_gy;
   logic [GRAD_BITS-1:0]        w_abs_x;
   logic [GRAD_BITS-1:0]        w_abs_y;
   logic [GRAD_BITS:0]          w_mag_sum;
   logic [SOBEL_DWIDTH-1:0]     w_mag;
   logic [SOBEL_DWIDTH-1:0]     r_mag;
   logic                        r_mag_vld;
   logic                        w_sob_full;
   logic                        w_sob_pop;
   logic [SCW-1:0]              w_sob_count;
   logic [SCW:0]                w_sob_occ;

   sync_fifo #(.DWIDTH(RGB_DWIDTH), .DEPTH(RGB_BUFFER)) u_rgb_fifo (
      .i_clk(clock), .i_rst(reset),
      .i_wr_en(fifo_rgb_wr_en), .i_din(fifo_rgb_din), .o_full(fifo_rgb_full),
      .i_rd_en(w_rgb_pop), .o_dout(w_rgb_dout), .o_empty(w_rgb_empty),
      .o_count(w_rgb_count_unused)
   );

   // Occupancy after this edge, counting the word already in the stage register.
   assign w_gray_occ = {1'b0, w_gray_count} + (GCW+1)'(r_gray_vld) - (GCW+1)'(w_gray_pop);
   assign w_rgb_pop  = !w_rgb_empty && !w_gray_full && (w_gray_occ < (GCW+1)'(GRAYSCALE_BUFFER));

   for (genvar k = 0; k < NUM_GRAYSCALES; k++) begin : g_gray
      logic [9:0] w_sum;
      assign w_sum = 10'(w_rgb_dout[PIXEL_BITS*k +: BYTE])
                   + 10'(w_rgb_dout[PIXEL_BITS*k + BYTE +: BYTE])
                   + 10'(w_rgb_dout[PIXEL_BITS*k + 2*BYTE +: BYTE]);
      assign w_gray[BYTE*k +: BYTE] = BYTE'(w_sum / 10'd3);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_gray_vld <= 1'b0;
         r_gray_dat <= '0;
      end else begin
         r_gray_vld <= w_rgb_pop;
         if (w_rgb_pop) r_gray_dat <= w_gray;
      end
   end

   sync_fifo #(.DWIDTH(GRAYSCALE_DWIDTH), .DEPTH(GRAYSCALE_BUFFER)) u_gray_fifo (
      .i_clk(clock), .i_rst(reset),
      .i_wr_en(r_gray_vld), .i_din(r_gray_dat), .o_full(w_gray_full),
      .i_rd_en(w_gray_pop), .o_dout(w_gray_dout), .o_empty(w_gray_empty),
      .o_count(w_gray_count)
   );

   assign w_sob_pop  = fifo_sobel_rd_en && !fifo_sobel_empty;
   assign w_sob_occ  = {1'b0, w_sob_count} + (SCW+1)'(r_mag_vld) - (SCW+1)'(w_sob_pop);
   assign w_gray_pop = !w_gray_empty && !w_sob_full && (w_sob_occ < (SCW+1)'(SOBEL_BUFFER));

   // Window after the shift: c0 = r_win1, c1 = r_win2, c2 = incoming column.
   always_comb begin
      w_gx = (px(w_gray_dout, 0) + (px(w_gray_dout, 1) <<< 1) + px(w_gray_dout, 2))
           - (px(r_win1, 0) + (px(r_win1, 1) <<< 1) + px(r_win1, 2));
      w_gy = (px(r_win1, 2) + (px(r_win2, 2) <<< 1) + px(w_gray_dout, 2))
           - (px(r_win1, 0) + (px(r_win2, 0) <<< 1) + px(w_gray_dout, 0));
      w_abs_x   = w_gx[GRAD_BITS-1] ? -w_gx : w_gx;
      w_abs_y   = w_gy[GRAD_BITS-1] ? -w_gy : w_gy;
      w_mag_sum = {1'b0, w_abs_x} + {1'b0, w_abs_y};
      w_mag     = (w_mag_sum > (GRAD_BITS+1)'(255)) ? '1 : w_mag_sum[SOBEL_DWIDTH-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_win1    <= '0;
         r_win2    <= '0;
         r_mag     <= '0;
         r_mag_vld <= 1'b0;
      end else begin
         r_mag_vld <= w_gray_pop;
         if (w_gray_pop) begin
            r_win1 <= r_win2;
            r_win2 <= w_gray_dout;
            r_mag  <= w_mag;
         end
      end
   end

   sync_fifo #(.DWIDTH(SOBEL_DWIDTH), .DEPTH(SOBEL_BUFFER)) u_sobel_fifo (
      .i_clk(clock), .i_rst(reset),
      .i_wr_en(r_mag_vld), .i_din(r_mag), .o_full(w_sob_full),
      .i_rd_en(fifo_sobel_rd_en), .o_dout(fifo_sobel_dout), .o_empty(fifo_sobel_empty),
      .o_count(w_sob_count)
   );
endmodule

// File: tb/tb_dut_sobel_system.sv
// Directed + randomized bench for dut_sobel_system against a column-history Sobel model.
module tb_dut_sobel_system;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [71:0] fifo_rgb_din = '0;
   logic        fifo_rgb_wr_en = 1'b0;
   logic        fifo_rgb_full;
   logic [7:0]  fifo_sobel_dout;
   logic        fifo_sobel_empty;
   logic        fifo_sobel_rd_en = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          acc_cnt = 0;
   int          out_cnt = 0;
   logic        saw_full = 1'b0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [23:0] cols[$];

   always #5 clock = ~clock;

   dut_sobel_system dut (
      .clock(clock), .reset(reset),
      .fifo_rgb_din(fifo_rgb_din), .fifo_rgb_full(fifo_rgb_full), .fifo_rgb_wr_en(fifo_rgb_wr_en),
      .fifo_sobel_dout(fifo_sobel_dout), .fifo_sobel_empty(fifo_sobel_empty),
      .fifo_sobel_rd_en(fifo_sobel_rd_en)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [71:0] rand_word();
      logic [95:0] w;
      w = {$urandom(), $urandom(), $urandom()};
      return w[71:0];
   endfunction

   function automatic int gv(input logic [23:0] col, input int row);
      return int'(col[8*row +: 8]);
   endfunction

   function automatic logic [23:0] gray_col(input logic [71:0] w);
      logic [23:0] g;
      int s;
      for (int k = 0; k < 3; k++) begin
         s = int'(w[24*k +: 8]) + int'(w[24*k+8 +: 8]) + int'(w[24*k+16 +: 8]);
         g[8*k +: 8] = 8'(s / 3);
      end
      return g;
   endfunction

   task automatic model_reset();
      cols.delete();
      cols.push_back(24'd0);
      cols.push_back(24'd0);
      exp_q.delete();
   endtask

   task automatic model_accept(input logic [71:0] w);
      logic [23:0] a, b, c;
      int gx, gy, m;
      cols.push_back(gray_col(w));
      a = cols[cols.size()-3];
      b = cols[cols.size()-2];
      c = cols[cols.size()-1];
      gx = (gv(c,0) + 2*gv(c,1) + gv(c,2)) - (gv(a,0) + 2*gv(a,1) + gv(a,2));
      gy = (gv(a,2) + 2*gv(b,2) + gv(c,2)) - (gv(a,0) + 2*gv(b,0) + gv(c,0));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
      exp_q.push_back(8'(m));
      acc_cnt++;
      if (cols.size() > 3) void'(cols.pop_front());
   endtask

   // One clock: drive, note handshakes, check any popped byte, advance to #1 after the edge.
   task automatic cycle(input logic wr, input logic [71:0] din, input logic rd, output logic acc);
      logic       pop;
      logic [7:0] val;
      fifo_rgb_wr_en   = wr;
      fifo_rgb_din     = din;
      fifo_sobel_rd_en = rd;
      acc = wr && !fifo_rgb_full;
      pop = rd && !fifo_sobel_empty;
      val = fifo_sobel_dout;
      if (fifo_rgb_full) saw_full = 1'b1;
      if (pop) begin
         check("pop_has_expect", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("out_byte", 32'(val), 32'(exp_q.pop_front()));
         got_q.push_back(val);
         out_cnt++;
      end
      @(posedge clock);
      #1;
      if (acc) model_accept(din);
   endtask

   task automatic drain();
      int   t;
      logic a;
      t = 0;
      while ((exp_q.size() != 0 || !fifo_sobel_empty) && t < 300) begin
         cycle(1'b0, '0, 1'b1, a);
         t++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      check("drain_empty", 32'(fifo_sobel_empty), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        a;
      logic [71:0] w;
      logic [7:0]  uni_exp[10];
      logic [7:0]  edge_exp[8];
      int          base_out, base_acc, t, npix;

      uni_exp  = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      edge_exp = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
      model_reset();

      #2;
      check("rst_full", 32'(fifo_rgb_full), 32'd0);
      check("rst_empty", 32'(fifo_sobel_empty), 32'd1);
      check("rst_dout", 32'(fifo_sobel_dout), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Latency and uniform gray-128 stream
      got_q.delete();
      w = {3{24'h808080}};
      cycle(1'b1, w, 1'b0, a);
      check("lat_edge0_empty", 32'(fifo_sobel_empty), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b0, '0, 1'b0, a);
         check("lat_early_empty", 32'(fifo_sobel_empty), 32'd1);
      end
      cycle(1'b0, '0, 1'b0, a);
      check("lat_edge4_empty", 32'(fifo_sobel_empty), 32'd0);
      check("lat_edge4_dout", 32'(fifo_sobel_dout), 32'd255);
      for (int i = 0; i < 9; i++) cycle(1'b1, w, 1'b1, a);
      drain();
      check("uniform_count", 32'(got_q.size()), 32'd10);
      for (int i = 0; i < 10; i++) check("uniform_seq", 32'(got_q[i]), 32'(uni_exp[i]));

      // Grayscale arithmetic, observed at the converter register
      w = {8'd0, 8'd1, 8'd1, 8'd254, 8'd255, 8'd255, 8'd90, 8'd60, 8'd30};
      cycle(1'b1, w, 1'b0, a);
      cycle(1'b0, '0, 1'b0, a);
      check("gray_probe_vld", 32'(dut.r_gray_vld), 32'd1);
      check("gray_probe_dat", 32'(dut.r_gray_dat), 32'h00FE3C);
      drain();

      // Mid-operation reset with the pipeline backed up
      saw_full = 1'b0;
      for (int i = 0; i < 12; i++) cycle(1'b1, rand_word(), 1'b0, a);
      check("pre_reset_full", 32'(saw_full), 32'd1);
      fifo_rgb_wr_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_full", 32'(fifo_rgb_full), 32'd0);
      check("midrst_empty", 32'(fifo_sobel_empty), 32'd1);
      check("midrst_dout", 32'(fifo_sobel_dout), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
      base_out = out_cnt;
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, a);
      check("post_rst_no_data", 32'(out_cnt - base_out), 32'd0);
      check("post_rst_empty", 32'(fifo_sobel_empty), 32'd1);

      // Vertical edge from a cleared window
      got_q.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, 72'd0, 1'b1, a);
      for (int i = 0; i < 5; i++) cycle(1'b1, {3{24'hFFFFFF}}, 1'b1, a);
      drain();
      check("edge_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) check("edge_seq", 32'(edge_exp[i]), 32'(got_q[i]));

      // Backpressure: output stalled while 20 writes are attempted
      saw_full = 1'b0;
      base_acc = acc_cnt;
      base_out = out_cnt;
      for (int i = 0; i < 20; i++) cycle(1'b1, rand_word(), 1'b0, a);
      check("bp_full_seen", 32'(saw_full), 32'd1);
      check("bp_some_dropped", 32'((acc_cnt - base_acc) < 20), 32'd1);
      drain();
      check("bp_one_per_word", 32'(out_cnt - base_out), 32'(acc_cnt - base_acc));

      // Random handshakes on both sides
      base_acc = acc_cnt;
      base_out = out_cnt;
      for (int i = 0; i < 800; i++)
         cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 2) != 0), a);
      drain();
      check("rand_one_per_word", 32'(out_cnt - base_out), 32'(acc_cnt - base_acc));

      // Small image with free-running handshake; each word held until accepted
      npix = 48 * 36;
      base_acc = acc_cnt;
      base_out = out_cnt;
      w = rand_word();
      t = 0;
      for (int i = 0; i < npix && t < 3 * npix; t++) begin
         cycle(1'b1, w, 1'b1, a);
         if (a) begin
            i++;
            w = rand_word();
         end
      end
      check("img_accepted", 32'(acc_cnt - base_acc), 32'(npix));
      drain();
      check("img_outputs", 32'(out_cnt - base_out), 32'(npix));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
